// File: rtl/su_pkg.sv
// Shared definitions for the shift-unit arbiter: shift-function encodings
// and the statistics counter width.
package su_pkg;

    typedef logic [1:0] sf_t;

    localparam sf_t SF_SLL = 2'b00;
    localparam sf_t SF_SRL = 2'b10;
    localparam sf_t SF_SRA = 2'b11;

    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter. Searches req starting at ptr and
// wrapping; grant is one-hot for the winner when en is high, else zero.
// grant_idx reports the winner index regardless of en.
module rr_arb #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic        w_found;
    int unsigned w_pos;

    // First requesting index at or after ptr, in wrapping order.
    always_comb begin
        w_found   = 1'b0;
        w_pos     = 0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_pos = (int'(ptr) + i) % NREQ;
            if (!w_found && req[w_pos]) begin
                w_found   = 1'b1;
                grant_idx = ID_W'(w_pos);
            end
        end
    end

    // Expand the winner index into a gated one-hot grant.
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant[i] = en && w_found && (grant_idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/su.sv
// Combinational shift unit: SLL / SRL / SRA of operand a by amount b.
// Encoding 01 is treated as SLL; b wraps modulo N by its width.
module su
    import su_pkg::*;
#(
    parameter int unsigned N = 32,
    localparam int unsigned K = $clog2(N)
) (
    input  logic [N-1:0] a,
    input  logic [K-1:0] b,
    input  sf_t          sf,
    output logic [N-1:0] y
);

    // Decode shift function; anything not SRL/SRA is a left shift.
    always_comb begin
        y = a << b;
        case (sf)
            SF_SRL:  y = a >> b;
            SF_SRA:  y = $unsigned($signed(a) >>> b);
            default: y = a << b;
        endcase
    end

endmodule

// File: rtl/su_arbiter.sv
// Shares one combinational shift unit between NREQ requesters with
// round-robin arbitration and a single registered result slot.
// A new op is accepted whenever the slot is empty or being drained the
// same cycle, giving one op per cycle when consumers keep up.
// Optional macro SU_ARBITER_STATS_EN adds per-requester grant counters
// and a stall counter, all saturating.
module su_arbiter
    import su_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 4,
    localparam int unsigned K    = $clog2(N),
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*N-1:0]      req_a,
    input  logic [NREQ*K-1:0]      req_b,
    input  logic [NREQ*2-1:0]      req_sf,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
`ifdef SU_ARBITER_STATS_EN
    output logic [NREQ*STAT_W-1:0] grant_cnt,
    output logic [STAT_W-1:0]      stall_cnt,
`endif
    output logic [N-1:0]           resp_data
);

    logic [NREQ-1:0] r_resp_valid;
    logic [N-1:0]    r_resp_data;
    logic [ID_W-1:0] r_owner;
    logic [ID_W-1:0] r_rr_ptr;

    logic            w_out_full;
    logic            w_drain;
    logic            w_can_accept;
    logic            w_accept;
    logic [NREQ-1:0] w_grant;
    logic [ID_W-1:0] w_grant_idx;
    logic [N-1:0]    w_sel_a;
    logic [K-1:0]    w_sel_b;
    sf_t             w_sel_sf;
    logic [N-1:0]    w_su_y;

    // Only the owner's resp_ready matters; other bits are ignored.
    assign w_out_full   = |r_resp_valid;
    assign w_drain      = r_resp_valid[r_owner] & resp_ready[r_owner];
    assign w_can_accept = !w_out_full | w_drain;
    // Grants are gated by reset so req_ready reads zero while in reset.
    assign w_accept     = |(req_valid & w_grant);

    rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .en        (w_can_accept & !reset),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign req_ready = w_grant;

    // Route the winner's operands to the shared shift unit.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_sf = SF_SLL;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_sel_a  = req_a[i*N +: N];
                w_sel_b  = req_b[i*K +: K];
                w_sel_sf = req_sf[i*2 +: 2];
            end
        end
    end

    su #(
        .N (N)
    ) u_su (
        .a  (w_sel_a),
        .b  (w_sel_b),
        .sf (w_sel_sf),
        .y  (w_su_y)
    );

    // Result slot: load on accept (overwriting a draining result), clear on drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
        end else if (w_accept) begin
            r_resp_valid <= w_grant;
            r_resp_data  <= w_su_y;
            r_owner      <= w_grant_idx;
            r_rr_ptr     <= (w_grant_idx == ID_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end else if (w_drain) begin
            r_resp_valid <= '0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

`ifdef SU_ARBITER_STATS_EN
    logic [NREQ*STAT_W-1:0] r_grant_cnt;
    logic [STAT_W-1:0]      r_stall_cnt;
    logic                   w_stall;

    assign w_stall = w_out_full & !w_drain & (|req_valid);

    // Saturating per-requester accept counters and stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (w_grant[i] && req_valid[i] && (r_grant_cnt[i*STAT_W +: STAT_W] != '1)) begin
                    r_grant_cnt[i*STAT_W +: STAT_W] <= r_grant_cnt[i*STAT_W +: STAT_W] + 1'b1;
                end
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_su_arbiter.sv
// Directed self-checking bench for su_arbiter (N=32, NREQ=4).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_su_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int K    = 5;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*K-1:0] req_b;
    logic [NREQ*2-1:0] req_sf;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [N-1:0]      resp_data;
`ifdef SU_ARBITER_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
    logic [15:0]        stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    su_arbiter #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sf     (req_sf),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
`ifdef SU_ARBITER_STATS_EN
        .grant_cnt  (grant_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .resp_data  (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [31:0] a, input logic [4:0] b,
                          input logic [1:0] sf);
        req_a[i*N +: N]  = a;
        req_b[i*K +: K]  = b;
        req_sf[i*2 +: 2] = sf;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid);
        end
        n_checks++;
        if (resp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp_data: got %h expected 00000000", resp_data);
        end
        reset     = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_op(0, 32'h8000_0001, 5'd4, 2'b11);
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0001 || resp_data !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL single_resp: got %b/%h expected 0001/f8000000", resp_valid, resp_data);
        end
        resp_ready = 4'b0001;
        @(negedge clk);
        resp_ready = '0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0000 || resp_data !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL single_drain: got %b/%h expected 0000/f8000000", resp_valid, resp_data);
        end
    endtask

    task automatic test_shift_funcs();
        logic [31:0] va[5];
        logic [4:0]  vb[5];
        logic [1:0]  vs[5];
        logic [31:0] ve[5];
        va = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h7000_0000};
        vb = '{5'd4, 5'd4, 5'd4, 5'd31, 5'd31};
        vs = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        ve = '{32'h0000_0010, 32'h0000_0010, 32'h0800_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        do_reset();
        resp_ready = 4'b1111;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5) begin
                set_op(0, va[i], vb[i], vs[i]);
                req_valid = 4'b0001;
            end else begin
                req_valid = '0;
            end
            #1;
            if (i < 5) begin
                n_checks++;
                if (req_ready !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL sf_ready[%0d]: got %b expected 0001", i, req_ready);
                end
            end
            if (i > 0) begin
                n_checks++;
                if (resp_valid !== 4'b0001 || resp_data !== ve[i-1]) begin
                    n_fail++;
                    $display("FAIL sf_result[%0d]: got %b/%h expected 0001/%h",
                             i - 1, resp_valid, resp_data, ve[i-1]);
                end
            end
        end
        resp_ready = '0;
    endtask

    task automatic test_round_robin();
        int order[8];
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'h1, 5'(i), 2'b00);
        resp_ready = 4'b1111;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) begin
                n_checks++;
                if (req_ready !== 4'(1 << order[k])) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready,
                             4'(1 << order[k]));
                end
            end
            if (k > 0) begin
                n_checks++;
                if (resp_valid !== 4'(1 << order[k-1]) || resp_data !== 32'(1 << order[k-1])) begin
                    n_fail++;
                    $display("FAIL rr_resp[%0d]: got %b/%h expected %b/%h", k, resp_valid,
                             resp_data, 4'(1 << order[k-1]), 32'(1 << order[k-1]));
                end
            end
        end
`ifdef SU_ARBITER_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            n_checks++;
            if (grant_cnt[i*16 +: 16] !== 16'd2) begin
                n_fail++;
                $display("FAIL grant_cnt[%0d]: got %0d expected 2", i, grant_cnt[i*16 +: 16]);
            end
        end
`endif
        resp_ready = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(2, 32'h0000_00F0, 5'd4, 2'b10);
        set_op(1, 32'h0000_0003, 5'd1, 2'b00);
        resp_ready = 4'b0000;
        req_valid  = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_first_grant: got %b expected 0100", req_ready);
        end
        // Non-owner resp_ready bits asserted during the stall must be ignored.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid  = 4'b0010;
            resp_ready = 4'b1011;
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || resp_valid !== 4'b0100 || resp_data !== 32'h0F) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got ready %b valid %b data %h expected 0000/0100/0000000f",
                         c, req_ready, resp_valid, resp_data);
            end
        end
        @(negedge clk);
        resp_ready = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_no_bubble: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid  = '0;
        resp_ready = '0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0010 || resp_data !== 32'h6) begin
            n_fail++;
            $display("FAIL bp_second_resp: got %b/%h expected 0010/00000006", resp_valid, resp_data);
        end
`ifdef SU_ARBITER_STATS_EN
        n_checks++;
        if (stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'h1, 5'(i), 2'b00);
        resp_ready = 4'b1111;
        req_valid  = 4'b1000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_first: got %b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001 || resp_valid !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got ready %b valid %b expected 0001/1000", req_ready,
                     resp_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b1000 || resp_valid !== 4'b0001 || resp_data !== 32'h1) begin
            n_fail++;
            $display("FAIL wrap_next: got ready %b valid %b data %h expected 1000/0001/00000001",
                     req_ready, resp_valid, resp_data);
        end
        req_valid  = '0;
        resp_ready = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_op(2, 32'h0000_00F0, 5'd4, 2'b10);
        set_op(1, 32'h0000_0003, 5'd1, 2'b00);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_pending: got %b expected 0100", resp_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0000 || resp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_cleared: got %b/%h expected 0000/00000000", resp_valid, resp_data);
        end
        req_valid = 4'b0110;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_restart: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0010 || resp_data !== 32'h6) begin
            n_fail++;
            $display("FAIL mid_resp: got %b/%h expected 0010/00000006", resp_valid, resp_data);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_sf     = '0;
        test_reset();
        test_single();
        test_shift_funcs();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
